mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

- Shares the single-port unified instruction/data memory of `pipeline_top` between the IF stage (fetch) and the MEM stage (load/store).
- Sequences each access through a fixed-latency memory FSM and returns read data with a one-cycle valid pulse.
- Raises per-requester stall signals that freeze the pipeline stage while its access is outstanding.
- Gives the data port priority; a starvation counter bounds fetch delay.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `LAT`, default 2: memory read latency in cycles from the `mem_en` cycle to `mem_rdata` valid; legal range is 1 or more.
- `STARVE_MAX`, default 4: consecutive data grants allowed while a fetch waits; legal range is 1 or more.
- `CLK` in 1: the single clock; all state updates on the rising edge.
- `RST` in 1: reset, synchronous and active-low.
- `if_req` in 1: fetch request; held with `if_addr` stable until `if_valid`.
- `if_addr` in ADDR_W: fetch address.
- `if_rdata` out DATA_W: fetched instruction; meaningful only when `if_valid`=1.
- `if_valid` out 1: one-cycle completion pulse for the fetch.
- `if_stall` out 1: equals `if_req & ~if_valid`.
- `d_req` in 1: data request; held with `d_we`, `d_addr` and `d_wdata` stable until `d_valid`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: store data.
- `d_rdata` out DATA_W: load data.
- `d_valid` out 1: one-cycle completion pulse for the data access.
- `d_stall` out 1: equals `d_req & ~d_valid`.
- `mem_en` out 1: memory access strobe, exactly one cycle per transaction.
- `mem_we` out 1: memory write enable, qualified by `mem_en`.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data.

## Operation
- **States:** ARB_IDLE → ARB_ISSUE → ARB_WAIT → ARB_IDLE.
- **ARB_IDLE, arbitration:**
  - Only `d_req`: grant D.
  - Only `if_req`: grant IF.
  - Both requesting: grant IF if `starve_cnt == STARVE_MAX`, else grant D.
  - On grant: latch the owner and address/we/wdata into registers, then go to ARB_ISSUE.
- **ARB_ISSUE:** `mem_en`=1 and the memory bus is driven from the latched registers.
  - Store: go directly to ARB_IDLE with `d_valid` pulsing in that cycle.
  - Load or fetch: load the latency counter with LAT and go to ARB_WAIT.
- **ARB_WAIT:** decrement the counter each cycle. In the cycle the counter reads 1, capture `mem_rdata` into the owner's rdata register, then go to ARB_IDLE with the owner's valid pulsing.
- **Starvation counter:**
  - Increments, saturating at STARVE_MAX, on each D grant made while `if_req`=1.
  - Clears to 0 on each IF grant.
  - Width is $clog2(STARVE_MAX+1).
- **Request held through valid:** a request still asserted in the valid cycle is treated as a new request and arbitrated in that same cycle. This is how the next fetch (new PC) follows immediately.
- **Rdata registers:** hold their last captured value until the next capture.
- Addresses and data pass through unmodified; there is no alignment checking.

## Timing
- Cycle 0 is the ARB_IDLE cycle in which a request is granted.
- **Load/fetch:**
  - `mem_en` in cycle 1.
  - `mem_rdata` sampled in cycle 1+LAT.
  - valid and rdata in cycle 2+LAT.
  - Throughput is one read per LAT+2 cycles.
- **Store:**
  - `mem_en` and `mem_we` in cycle 1.
  - `d_valid` in cycle 2.
  - Throughput is one store per 2 cycles.
- **Reset values (while `RST`=0):**
  - Outputs `mem_en`, `mem_we`, `if_valid`, `d_valid`, `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` are 0.
  - Internal: state is ARB_IDLE, `starve_cnt` and the latency counter are 0.
- **Stall outputs under reset:** the stalls follow their requests combinationally, so they may be 1 during reset if requests are high.
- **Reset mid-transaction:** the in-flight access is dropped, with no valid and no capture. The first edge with `RST`=1 arbitrates as cycle 0.
- **Registered outputs:** valid pulses last exactly one cycle, and `mem_en` is never asserted for two consecutive cycles.
- **Request dropped while outstanding:** the transaction still completes and the valid pulse is still produced. This is a protocol violation by the requester and is flagged by a bench assertion only.

## Structure
- Package `pipeline_pkg` gains:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_t`
  - `typedef enum logic {OWN_IF, OWN_D} arb_owner_t`
- One natural sub-module: `sat_counter`, a parameterized saturating up-counter with synchronous clear, used for `starve_cnt`.
- The latency counter stays inline.

## Test plan
All scenarios use LAT=2 and STARVE_MAX=4.
- **Reset:** `RST`=0 for 3 cycles with both requests high → `mem_en`=0, valids=0 and rdata=0 throughout; first `mem_en` occurs in cycle 1 after release, for D.
- **Single fetch:** `if_addr`=0x00000010, memory returns 0x00500093 in cycle 3 → `mem_en`=1 with `mem_addr`=0x10 and `mem_we`=0 in cycle 1; `if_valid`=1 with `if_rdata`=0x00500093 in cycle 4; `if_stall`=1 in cycles 0–3.
- **Store:** `d_addr`=0x100, `d_wdata`=0xDEADBEEF → `mem_en`=1, `mem_we`=1, `mem_wdata`=0xDEADBEEF in cycle 1; `d_valid` in cycle 2; `if_valid` never asserted.
- **Contention:** `if_req` and `d_req` (loads) held continuously → grant order D,D,D,D,IF,D,D,D,D,IF; `starve_cnt` reads 0,1,2,3,4,0.
- **Back-to-back fetch:** `if_req` held high through each valid → `mem_en` in cycles 1, 5, 9, 13; each `if_valid` coincides with the next grant cycle.
- **Reset mid-load:** `RST`=0 in cycle 2 of a D load → no `d_valid` and `d_rdata` stays 0; after release the held request reissues, with `mem_en` one cycle after release.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline memory-port arbiter: FSM states and
// the identity of the requester that currently owns the memory port.
package pipeline_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; tracks how many data
// grants in a row have been made while a fetch was kept waiting.
module sat_counter #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Clear has priority over increment; the count holds at MAX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != W'(MAX))) begin
            cnt <= cnt + W'(1'b1);
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port instruction/data memory between fetch and
// load/store; data wins ties unless fetch has waited STARVE_MAX grants.
module mem_port_arbiter
    import pipeline_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int LW = $clog2(LAT + 1);

    arb_state_t      state_r;
    arb_owner_t      owner_r;
    logic [LW-1:0]   lat_cnt_r;
    logic [SW-1:0]   starve_cnt_s;
    logic            grant_d_s;
    logic            grant_if_s;
    logic            starve_inc_s;
    logic            starve_clr_s;

    // Stalls are combinational so a stage freezes in the request cycle itself.
    assign if_stall = if_req & ~if_valid;
    assign d_stall  = d_req & ~d_valid;

    // Arbitration: data priority, fetch forced through once starved.
    always_comb begin
        grant_d_s  = 1'b0;
        grant_if_s = 1'b0;
        if (d_req && if_req) begin
            if (starve_cnt_s == SW'(STARVE_MAX)) begin
                grant_if_s = 1'b1;
            end else begin
                grant_d_s = 1'b1;
            end
        end else if (d_req) begin
            grant_d_s = 1'b1;
        end else if (if_req) begin
            grant_if_s = 1'b1;
        end else begin
            grant_d_s  = 1'b0;
            grant_if_s = 1'b0;
        end
    end

    assign starve_inc_s = (state_r == ARB_IDLE) && grant_d_s && if_req;
    assign starve_clr_s = (state_r == ARB_IDLE) && grant_if_s;

    sat_counter #(
        .MAX (STARVE_MAX),
        .W   (SW)
    ) u_starve_cnt (
        .clk   (CLK),
        .rst_n (RST),
        .clr   (starve_clr_s),
        .inc   (starve_inc_s),
        .cnt   (starve_cnt_s)
    );

    // Access sequencer: grant, one-cycle strobe, fixed-latency wait, valid pulse.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r   <= ARB_IDLE;
            owner_r   <= OWN_IF;
            lat_cnt_r <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state_r)
                ARB_IDLE: begin
                    if (grant_d_s || grant_if_s) begin
                        owner_r   <= grant_d_s ? OWN_D : OWN_IF;
                        mem_en    <= 1'b1;
                        mem_we    <= grant_d_s & d_we;
                        mem_addr  <= grant_d_s ? d_addr : if_addr;
                        mem_wdata <= grant_d_s ? d_wdata : mem_wdata;
                        state_r   <= ARB_ISSUE;
                    end else begin
                        state_r <= ARB_IDLE;
                    end
                end
                ARB_ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    // Stores need no read-back, so they complete right after the strobe.
                    if ((owner_r == OWN_D) && mem_we) begin
                        d_valid <= 1'b1;
                        state_r <= ARB_IDLE;
                    end else begin
                        lat_cnt_r <= LW'(LAT);
                        state_r   <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    lat_cnt_r <= lat_cnt_r - LW'(1'b1);
                    if (lat_cnt_r == LW'(1'b1)) begin
                        if (owner_r == OWN_D) begin
                            d_rdata <= mem_rdata;
                            d_valid <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_valid <= 1'b1;
                        end
                        state_r <= ARB_IDLE;
                    end else begin
                        state_r <= ARB_WAIT;
                    end
                end
                default: begin
                    state_r <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-schedule model
// predicts every strobe, valid pulse and rdata value cycle by cycle.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int SMAX = 4;
    localparam int NCYC = 4000;

    logic          CLK = 1'b0;
    logic          RST;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          if_stall;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          d_stall;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .LAT        (LAT),
        .STARVE_MAX (SMAX)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .if_stall  (if_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .d_stall   (d_stall),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Schedule of the transaction in flight, expressed as absolute cycle numbers.
    int          next_arb;
    int          en_cyc;
    int          rd_cyc;
    int          val_cyc;
    bit          val_is_d;
    bit          val_has_data;
    int          starve;
    bit          rst_pend;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] rd_val;
    logic [31:0] exp_if_rd;
    logic [31:0] exp_d_rd;
    bit          gd;
    bit          gi;
    bit          ifv_now;
    bit          dv_now;

    initial begin
        RST       = 1'b0;
        if_req    = 1'b1;
        if_addr   = $urandom;
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = $urandom;
        d_wdata   = $urandom;
        mem_rdata = '0;
        next_arb  = 0;
        en_cyc    = -1;
        rd_cyc    = -1;
        val_cyc   = -1;
        val_is_d  = 1'b0;
        val_has_data = 1'b0;
        starve    = 0;
        rst_pend  = 1'b0;
        exp_we    = 1'b0;
        exp_addr  = '0;
        exp_wdata = '0;
        rd_val    = '0;
        exp_if_rd = '0;
        exp_d_rd  = '0;

        for (int c = 0; c < NCYC; c++) begin
            ifv_now = (val_cyc == c) && !val_is_d;
            dv_now  = (val_cyc == c) && val_is_d;

            // Registered outputs for this cycle.
            if (c > 0) begin
                if (rst_pend) begin
                    exp_if_rd = '0;
                    exp_d_rd  = '0;
                    check_eq("rst_mem_addr", mem_addr, 32'h0);
                    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
                    check_eq("rst_mem_we", {31'b0, mem_we}, 32'h0);
                end
                if ((val_cyc == c) && val_has_data) begin
                    if (val_is_d) exp_d_rd = rd_val;
                    else          exp_if_rd = rd_val;
                end
                check_eq("mem_en", {31'b0, mem_en}, {31'b0, (en_cyc == c)});
                if (en_cyc == c) begin
                    check_eq("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
                    check_eq("mem_addr", mem_addr, exp_addr);
                    if (exp_we) check_eq("mem_wdata", mem_wdata, exp_wdata);
                end
                check_eq("if_valid", {31'b0, if_valid}, {31'b0, ifv_now});
                check_eq("d_valid", {31'b0, d_valid}, {31'b0, dv_now});
                check_eq("if_rdata", if_rdata, exp_if_rd);
                check_eq("d_rdata", d_rdata, exp_d_rd);
            end
            rst_pend = 1'b0;

            // Requesters obey the hold-until-valid protocol.
            RST = (c < 3) ? 1'b0 : (($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1);
            if (if_req && ifv_now) begin
                if ($urandom_range(0, 3) != 0) if_addr = $urandom;
                else                           if_req = 1'b0;
            end else if (!if_req && ($urandom_range(0, 1) == 0)) begin
                if_req  = 1'b1;
                if_addr = $urandom;
            end
            if ((d_req && dv_now) || (!d_req && ($urandom_range(0, 2) == 0))) begin
                d_req   = (!d_req) || ($urandom_range(0, 3) != 0);
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            mem_rdata = (c == rd_cyc) ? rd_val : $urandom;

            #1;
            if (c > 0) begin
                check_eq("if_stall", {31'b0, if_stall}, {31'b0, if_req & ~ifv_now});
                check_eq("d_stall", {31'b0, d_stall}, {31'b0, d_req & ~dv_now});
            end

            // Reference arbitration for this cycle.
            if (!RST) begin
                en_cyc   = -1;
                rd_cyc   = -1;
                val_cyc  = -1;
                starve   = 0;
                next_arb = c + 1;
                rst_pend = 1'b1;
            end else if (c == next_arb) begin
                gd = d_req && (!if_req || (starve != SMAX));
                gi = if_req && !gd;
                if (gd || gi) begin
                    en_cyc    = c + 1;
                    exp_we    = gd && d_we;
                    exp_addr  = gd ? d_addr : if_addr;
                    exp_wdata = d_wdata;
                    val_is_d  = gd;
                    if (exp_we) begin
                        val_cyc      = c + 2;
                        val_has_data = 1'b0;
                    end else begin
                        rd_cyc       = c + 1 + LAT;
                        val_cyc      = c + 2 + LAT;
                        rd_val       = $urandom;
                        val_has_data = 1'b1;
                    end
                    next_arb = val_cyc;
                    if (gd && if_req) starve = (starve < SMAX) ? starve + 1 : SMAX;
                    if (gi) starve = 0;
                end else begin
                    next_arb = c + 1;
                end
            end

            @(posedge CLK);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
